// File: rtl/repeat_stream_pkg.sv
// repeat_stream_pkg: shared stream-primitive token constants, helpers and FSM states
package repeat_stream_pkg;
  localparam int TOKEN_W = 17;
  localparam int CTRL_BIT = 16;
  localparam logic [15:0] DONE_PAYLOAD = 16'h0100;
  localparam logic [TOKEN_W-1:0] DONE_TOK = {1'b1, DONE_PAYLOAD};
  typedef enum logic [1:0] {START, REPEAT, ADVANCE, DONE} state_t;
  function automatic logic is_done(input logic [TOKEN_W-1:0] t);
    return t[CTRL_BIT] && t[CTRL_BIT-1:0] == DONE_PAYLOAD;
  endfunction
  function automatic logic is_stop(input logic [TOKEN_W-1:0] t);
    return t[CTRL_BIT] && t[CTRL_BIT-1:0] < DONE_PAYLOAD;
  endfunction
  function automatic logic [15:0] stop_level(input logic [TOKEN_W-1:0] t);
    return t[CTRL_BIT] ? t[CTRL_BIT-1:0] : 16'h0;
  endfunction
endpackage

// File: rtl/repeat_stream_fifo.sv
// reg_fifo: register FIFO that honours a simultaneous push and pop while full
// Ports: clk, rst (async high), en (update enable), push/din, pop/dout, full, empty
module reg_fifo #(
  parameter int W = 17,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign do_pop = en & pop & ~empty;
  assign do_push = en & push & (~full | do_pop);
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign dout = mem[rd];
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
  endfunction
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd <= '0;
      wr <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) mem[wr] <= din;
      if (do_push) wr <= inc(wr);
      if (do_pop) rd <= inc(rd);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/repeat_stream.sv
// repeat_stream: emits each proc reference once per repsig repeat token, turning repsig stops into output stops
// Ports: clk, rst (async high), clk_en, tile_en, proc/repsig input streams, ref output stream,
// err_out sticky mismatch flag (present only when REPEAT_STREAM_ERR_EN is defined)
module repeat_stream
  import repeat_stream_pkg::*;
#(
  parameter int DATA_W = TOKEN_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              tile_en,
  input  logic [DATA_W-1:0] proc_data_in,
  input  logic              proc_data_in_valid,
  output logic              proc_data_in_ready,
  input  logic [DATA_W-1:0] repsig_data_in,
  input  logic              repsig_data_in_valid,
  output logic              repsig_data_in_ready,
  output logic [DATA_W-1:0] ref_data_out,
  output logic              ref_data_out_valid,
  input  logic              ref_data_out_ready
`ifdef REPEAT_STREAM_ERR_EN
  ,
  output logic              err_out
`endif
);
  logic [DATA_W-1:0] p_tok, r_tok, o_din;
  logic p_full, p_empty, r_full, r_empty, o_full, o_empty;
  logic p_pop, r_pop, o_push;
  logic p_v, r_v, both, go, fin, p_d, p_s, r_d;
  state_t state, state_n, cur;
  assign proc_data_in_ready = tile_en & ~p_full;
  assign repsig_data_in_ready = tile_en & ~r_full;
  assign ref_data_out_valid = tile_en & ~o_empty;
  reg_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_proc (
    .clk, .rst, .en(clk_en), .push(proc_data_in_valid & proc_data_in_ready), .pop(p_pop),
    .din(proc_data_in), .dout(p_tok), .full(p_full), .empty(p_empty)
  );
  reg_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_repsig (
    .clk, .rst, .en(clk_en), .push(repsig_data_in_valid & repsig_data_in_ready), .pop(r_pop),
    .din(repsig_data_in), .dout(r_tok), .full(r_full), .empty(r_empty)
  );
  reg_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_out (
    .clk, .rst, .en(clk_en), .push(o_push), .pop(ref_data_out_valid & ref_data_out_ready),
    .din(o_din), .dout(ref_data_out), .full(o_full), .empty(o_empty)
  );
  assign p_v = tile_en & ~p_empty;
  assign r_v = tile_en & ~r_empty;
  assign both = p_v & r_v;
  assign go = both & ~o_full;
  assign p_d = is_done(p_tok);
  assign p_s = is_stop(p_tok);
  assign r_d = is_done(r_tok);
  assign fin = go & p_d & r_d;
  // A data head seen in START is acted on as REPEAT in the same cycle, keeping input-to-output latency at two cycles
  assign cur = (state == START && both && !p_tok[CTRL_BIT]) ? REPEAT : state;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= START;
    else if (clk_en) state <= state_n;
  always_comb begin
    state_n = state;
    case (cur)
      START:   state_n = (both & p_d) ? DONE : START;
      REPEAT:  state_n = (go & r_tok[CTRL_BIT]) ? ADVANCE : REPEAT;
      ADVANCE: state_n = (p_v & ~p_s) ? (p_d ? DONE : REPEAT) : ADVANCE;
      DONE:    state_n = fin ? START : DONE;
      default: state_n = START;
    endcase
  end
  always_comb begin
    p_pop = 1'b0;
    r_pop = 1'b0;
    o_push = 1'b0;
    o_din = p_tok;
    case (cur)
      START:   p_pop = both & p_s;
      REPEAT: begin
        o_push = go & ~r_d;
        o_din = r_tok[CTRL_BIT] ? r_tok : p_tok;
        r_pop = go & ~r_d;
        p_pop = go & r_tok[CTRL_BIT];
      end
      ADVANCE: p_pop = p_v & p_s;
      DONE: begin
        o_push = fin;
        o_din = DONE_TOK;
        r_pop = (r_v & ~r_d) | fin;
        p_pop = (p_v & ~p_d) | fin;
      end
      default: ;
    endcase
  end
`ifdef REPEAT_STREAM_ERR_EN
  logic err_set;
  assign err_set = (cur == REPEAT && go && r_d) || (cur == DONE && ((r_v && !r_d) || (p_v && !p_d)));
  always_ff @(posedge clk or posedge rst)
    if (rst) err_out <= 1'b0;
    else if (clk_en && err_set) err_out <= 1'b1;
`endif
endmodule

// File: tb/tb_repeat_stream.sv
// tb_repeat_stream: directed and randomized stream checks of repeat_stream against a queue-based reference model
module tb_repeat_stream;
  localparam logic [16:0] DT = 17'h10100;
  localparam logic [16:0] R = 17'h0002a;
  localparam logic [16:0] S0 = 17'h10000;
  localparam logic [16:0] S1 = 17'h10001;
  logic clk = 0, rst = 1, clk_en = 1, tile_en = 1;
  logic [16:0] proc_data_in = '0, repsig_data_in = '0, ref_data_out;
  logic proc_data_in_valid = 0, repsig_data_in_valid = 0, ref_data_out_ready = 0;
  logic proc_data_in_ready, repsig_data_in_ready, ref_data_out_valid;
`ifdef REPEAT_STREAM_ERR_EN
  logic err_out;
  logic exp_err;
`endif
  int tests = 0, fails = 0, cyc = 0, deadline = 0;
  bit abort = 0;
  logic [16:0] pq[$], rq[$], eq[$], got[$];

  repeat_stream dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .tile_en(tile_en),
    .proc_data_in(proc_data_in), .proc_data_in_valid(proc_data_in_valid), .proc_data_in_ready(proc_data_in_ready),
    .repsig_data_in(repsig_data_in), .repsig_data_in_valid(repsig_data_in_valid), .repsig_data_in_ready(repsig_data_in_ready),
    .ref_data_out(ref_data_out), .ref_data_out_valid(ref_data_out_valid), .ref_data_out_ready(ref_data_out_ready)
`ifdef REPEAT_STREAM_ERR_EN
    , .err_out(err_out)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic bit is_d(input logic [16:0] t);
    return t == DT;
  endfunction

  // Reference: walk proc refs, emit each once per repsig data token, copy the closing repsig stop,
  // drop proc stops, skip a ref on a premature repsig done, drain to one final done.
  function automatic void model();
    int pi = 0, ri = 0;
    eq.delete();
`ifdef REPEAT_STREAM_ERR_EN
    exp_err = 0;
`endif
    while (1) begin
      while (pq[pi][16] && !is_d(pq[pi])) pi++;
      if (is_d(pq[pi])) break;
      while (!rq[ri][16]) begin
        eq.push_back(pq[pi]);
        ri++;
      end
      if (is_d(rq[ri])) begin
`ifdef REPEAT_STREAM_ERR_EN
        exp_err = 1;
`endif
      end else begin
        eq.push_back(rq[ri]);
        ri++;
      end
      pi++;
    end
    while (!is_d(rq[ri])) begin
      ri++;
`ifdef REPEAT_STREAM_ERR_EN
      exp_err = 1;
`endif
    end
    eq.push_back(DT);
  endfunction

  task automatic do_reset();
    rst = 1;
    clk_en = 1;
    proc_data_in_valid = 0;
    repsig_data_in_valid = 0;
    ref_data_out_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic feed_proc();
    int i = 0;
    while (i < pq.size() && !abort && cyc < deadline) begin
      @(posedge clk);
      #1 proc_data_in_valid = ($urandom_range(3) != 0);
      proc_data_in = pq[i];
      @(negedge clk);
      if (proc_data_in_valid && proc_data_in_ready && clk_en) i++;
    end
    @(posedge clk);
    #1 proc_data_in_valid = 0;
  endtask

  task automatic feed_rep();
    int i = 0;
    while (i < rq.size() && !abort && cyc < deadline) begin
      @(posedge clk);
      #1 repsig_data_in_valid = ($urandom_range(3) != 0);
      repsig_data_in = rq[i];
      @(negedge clk);
      if (repsig_data_in_valid && repsig_data_in_ready && clk_en) i++;
    end
    @(posedge clk);
    #1 repsig_data_in_valid = 0;
  endtask

  task automatic sink(input int mode, input int rst_after);
    int idle = 0;
    got.delete();
    while (got.size() < eq.size() && idle < 500) begin
      @(negedge clk);
      ref_data_out_ready = mode == 0 ? 1'b1 : mode == 1 ? ~ref_data_out_ready : 1'($urandom_range(1));
      if (ref_data_out_valid && ref_data_out_ready && clk_en) begin
        got.push_back(ref_data_out);
        idle = 0;
      end else idle++;
      if (rst_after != 0 && got.size() == rst_after) begin
        @(posedge clk);
        #1 rst = 1;
        abort = 1;
        #1 check("rst_mid_valid", ref_data_out_valid, 0);
        check("rst_mid_data", ref_data_out, 0);
        return;
      end
    end
    @(negedge clk);
    ref_data_out_ready = 0;
  endtask

  task automatic stall(input int n);
    logic [19:0] snap;
    if (n == 0) return;
    repeat (n) @(posedge clk);
    #2 clk_en = 0;
    snap = {ref_data_out_valid, ref_data_out, proc_data_in_ready, repsig_data_in_ready};
    repeat (3) @(posedge clk);
    #2 check("clken_hold", {ref_data_out_valid, ref_data_out, proc_data_in_ready, repsig_data_in_ready}, snap);
    clk_en = 1;
  endtask

  task automatic run(input string tag, input int mode, input int rst_after, input int stall_at);
    do_reset();
    model();
    abort = 0;
    deadline = cyc + 3000;
    fork
      feed_proc();
      feed_rep();
      sink(mode, rst_after);
      stall(stall_at);
    join
    if (rst_after == 0) begin
      check({tag, "_len"}, got.size(), eq.size());
      for (int i = 0; i < eq.size() && i < got.size(); i++) check($sformatf("%s[%0d]", tag, i), got[i], eq[i]);
`ifdef REPEAT_STREAM_ERR_EN
      check({tag, "_err"}, err_out, exp_err);
`endif
    end
  endtask

  task automatic gen();
    int nref = $urandom_range(4, 1);
    pq.delete();
    rq.delete();
    for (int i = 0; i < nref; i++) begin
      pq.push_back({1'b0, 16'($urandom)});
      repeat ($urandom_range(3)) rq.push_back({1'b0, 16'($urandom)});
      if ($urandom_range(4) != 0) rq.push_back({1'b1, 16'($urandom_range(2))});
      if ($urandom_range(2) == 0) pq.push_back({1'b1, 16'($urandom_range(2))});
    end
    if ($urandom_range(4) == 0) rq.push_back(S0);
    pq.push_back(DT);
    rq.push_back(DT);
  endtask

  initial begin
    do_reset();
    check("reset_valid", ref_data_out_valid, 0);
    check("reset_data", ref_data_out, 0);
    check("reset_p_ready", proc_data_in_ready, 1);
    check("reset_r_ready", repsig_data_in_ready, 1);
`ifdef REPEAT_STREAM_ERR_EN
    check("reset_err", err_out, 0);
`endif
    tile_en = 0;
    #1 check("tile_p_ready", proc_data_in_ready, 0);
    check("tile_r_ready", repsig_data_in_ready, 0);
    tile_en = 1;
    pq = '{17'h5, DT};
    rq = '{R, R, R, S0, DT};
    run("basic", 0, 0, 0);
    pq = '{17'h3, 17'h7, S0, DT};
    rq = '{R, R, S0, R, S1, DT};
    run("two_refs", 0, 0, 0);
    pq = '{17'h5, DT};
    rq = '{R, R, R, S0, DT};
    run("backpressure", 1, 0, 0);
    run("reset_mid", 0, 2, 0);
    run("replay", 0, 0, 0);
    pq = '{17'h9, 17'h4, DT};
    rq = '{R, S0, DT};
    run("mismatch", 0, 0, 0);
    pq = '{17'h3, 17'h7, S0, DT};
    rq = '{R, R, S0, R, S1, DT};
    run("clk_en", 0, 0, 4);
    for (int k = 0; k < 20; k++) begin
      gen();
      run($sformatf("rand%0d", k), 2, 0, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/repeat_stream.md
# repeat_stream

Consumer end of the repeat-signal path in the sparse stream primitives. It takes a reference stream (proc) and a repeat-signal stream (repsig, as produced by the repeat signal generator) and emits each reference once per repeat token. It converts repsig stop boundaries into output stop tokens. It sits between the repeat signal generator and downstream intersect/read-scanner blocks.

## Interface
- DATA_W, 17: stream token width; bit 16 is the control flag, bits 15:0 are the payload.
- FIFO_DEPTH, 2: depth of each input FIFO and of the output FIFO.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- clk_en  in  1  global clock enable; when 0, all state is held
- tile_en  in  1  tile enable; when 0, all readies and valids are forced to 0
- proc_data_in  in  17  reference stream token
- proc_data_in_valid  in  1  proc token valid
- proc_data_in_ready  out  1  proc input FIFO not full
- repsig_data_in  in  17  repeat-signal token
- repsig_data_in_valid  in  1  repsig token valid
- repsig_data_in_ready  out  1  repsig input FIFO not full
- ref_data_out  out  17  output token
- ref_data_out_valid  out  1  output FIFO not empty
- ref_data_out_ready  in  1  downstream accept
- err_out  out  1  sticky protocol error flag; present only with REPEAT_STREAM_ERR_EN

## Operation
- Token encoding:
  - Data: bit16 = 0.
  - Stop S_k: bit16 = 1, payload = k, with k < 0x100.
  - Done D: bit16 = 1, payload = 0x0100.
  - Any repsig data token is a repeat token R.
- Transfer rule: a transfer occurs on valid & ready at the rising clk edge when clk_en = 1.
- FSM states: START, REPEAT, ADVANCE, DONE. Reset state is START.
- START: wait until both FIFO heads are valid.
  - proc head data → REPEAT.
  - proc head D → DONE.
  - proc head stop → pop it, no output.
- REPEAT: requires both heads valid and the output FIFO not full.
  - repsig R: push the proc data token, pop repsig only.
  - repsig S_k: push S_k, pop repsig and proc, → ADVANCE.
  - repsig D: mismatch. Pop proc with no output, → ADVANCE.
- ADVANCE: requires the proc head valid.
  - Stop token: pop it, no output; its level is already encoded in the repsig stop.
  - Data: → REPEAT.
  - D: → DONE.
- DONE: drain until both heads are D.
  - Non-D repsig token: pop, no output.
  - Non-D proc token: pop, no output.
  - Both heads D and output not full: push D, pop both, → START (ready for the next tile).
- Mismatch tokens are discarded as described above; the stream always terminates with exactly one D.

## Timing
- Reset values: all FIFOs empty.
  - ref_data_out_valid = 0, ref_data_out = 0, err_out = 0.
  - Both input readies = tile_en once rst is low.
- Latency: two cycles from both inputs accepted to ref_data_out_valid.
  - Cycle 1: tokens enter the input FIFOs.
  - Cycle 2: the FSM pushes the output FIFO.
- Throughput: one output token per cycle in steady-state REPEAT.
- Each FIFO accepts a simultaneous push and pop when full: ready stays low while full, but a pop and a push in the same cycle are both honoured.
- Output backpressure: if the output FIFO is full, the FSM stalls with no pops.
- clk_en = 0: no FIFO or FSM update; outputs hold their values.
- rst asserted mid-stream: FIFOs clear and the FSM returns to START immediately, asynchronously. Partially emitted streams are not completed.

## Configuration
- REPEAT_STREAM_ERR_EN defined: err_out exists.
  - Set on any mismatch: repsig D seen in REPEAT, or a non-D token popped in DONE.
  - Sticky until rst.
- REPEAT_STREAM_ERR_EN undefined: no err_out port and no error logic. Data behaviour is identical.

## Structure
- Shared package (stream primitives package) holds:
  - Token width.
  - Control bit index.
  - DONE payload constant 0x0100.
  - Token helper functions: is_done, is_stop, stop_level.
  - FSM state enum.
- Sub-module: reg_fifo (parameterised width/depth, push/pop/full/empty), instantiated three times.

## Test plan
- Basic repeat: proc [5, D], repsig [R, R, R, S0, D] → out [5, 5, 5, S0, D].
- Two refs with a stop: proc [3, 7, S0, D], repsig [R, R, S0, R, S1, D] → out [3, 3, S0, 7, S1, D].
- Output backpressure: same stimulus as the basic repeat with ref_data_out_ready toggling 1, 0, 1, 0 → identical token sequence, no drops or duplicates, pops only on accepted cycles.
- Reset mid-stream: assert rst after two output tokens → valid = 0 in the same cycle; replaying the full stream after release yields the complete correct output.
- Mismatch: proc [9, 4, D], repsig [R, S0, D] → out [9, S0, D]. With REPEAT_STREAM_ERR_EN, err_out = 1 when the extra 4 is popped and stays 1.
- clk_en low for three cycles mid-stream → no state change; output resumes unchanged when clk_en returns to 1.
